// File: rtl/riscv_shared_alu_pkg.sv
// Shared types for the EX-stage adapter to the shared DSP/ALU cluster.
// Operator and vector-mode encodings mirror riscv_defines.
package riscv_shared_alu_pkg;

    localparam int SHD_OP_WIDTH = 7;

    localparam logic [SHD_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
    localparam logic [SHD_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
    localparam logic [SHD_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
    localparam logic [SHD_OP_WIDTH-1:0] ALU_CLIP = 7'b0010110;

    localparam logic [2:0] VEC_MODE32 = 3'b000;
    localparam logic [2:0] VEC_MODE16 = 3'b010;
    localparam logic [2:0] VEC_MODE8  = 3'b011;

    localparam logic [31:0] SHD_TIMEOUT_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } shd_state_e;

    typedef struct packed {
        logic [SHD_OP_WIDTH-1:0] op;
        logic [31:0]             a;
        logic [31:0]             b;
        logic [31:0]             c;
        logic [2:0]              vec_mode;
    } shd_payload_t;

endpackage

// File: rtl/riscv_shared_alu_wdog.sv
// WAIT-state watchdog: counts cycles spent waiting for rvalid and flags
// the TIMEOUT_CYCLES-th one. Only instantiated with SHARED_ALU_TIMEOUT_EN.
module riscv_shared_alu_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside WAIT, so every WAIT entry starts from a clean count.
    assign cnt_d     = run_i ? cnt_q + CNT_W'(1) : '0;
    assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/riscv_alu_shared_if.sv
// EX-stage initiator for ops executed by the shared ALU cluster: req/gnt
// then rvalid, one outstanding transaction. Optional watchdog: SHARED_ALU_TIMEOUT_EN.
module riscv_alu_shared_if
    import riscv_shared_alu_pkg::*;
#(
    parameter int ALU_OP_WIDTH   = riscv_shared_alu_pkg::SHD_OP_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_a_i,
    input  logic [31:0]             operand_b_i,
    input  logic [31:0]             operand_c_i,
    input  logic [2:0]              vector_mode_i,
    input  logic                    flush_i,
    output logic [31:0]             result_o,
    output logic                    valid_o,
    output logic                    err_o,
    output logic                    ready_o,
    input  logic                    ex_ready_i,
    output logic                    shd_req_o,
    input  logic                    shd_gnt_i,
    output logic [ALU_OP_WIDTH-1:0] shd_op_o,
    output logic [95:0]             shd_operands_o,
    output logic [2:0]              shd_vec_mode_o,
    input  logic                    shd_rvalid_i,
    input  logic [31:0]             shd_rdata_i
);

    shd_state_e   state_q, state_d;
    shd_payload_t pl_q, pl_d;
    logic         kill_q, kill_d;
    logic [31:0]  result_q, result_d;
    logic         timeout;

`ifdef SHARED_ALU_TIMEOUT_EN
    logic err_q;

    riscv_shared_alu_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_q == ST_WAIT),
        .expired_o (timeout)
    );

    // err_o marks a DONE reached by the watchdog rather than by a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            err_q <= timeout && !shd_rvalid_i && !kill_q && !flush_i;
        end else if (state_q == ST_DONE && (flush_i || ex_ready_i)) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    // No watchdog in this build: WAIT only ends on rvalid.
    assign timeout = (TIMEOUT_CYCLES < 0);
    assign err_o   = 1'b0;

    assert property (@(posedge clk) disable iff (!rst_n) shd_rvalid_i |-> (state_q == ST_WAIT));
`endif

    always_comb begin
        state_d  = state_q;
        pl_d     = pl_q;
        kill_d   = kill_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i && !flush_i) begin
                    pl_d.op       = operator_i;
                    pl_d.a        = operand_a_i;
                    pl_d.b        = operand_b_i;
                    pl_d.c        = operand_c_i;
                    pl_d.vec_mode = vector_mode_i;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                // req is never withdrawn; a flush only marks the response for discard.
                if (flush_i) kill_d = 1'b1;
                if (shd_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (shd_rvalid_i || timeout) begin
                    result_d = shd_rvalid_i ? shd_rdata_i : SHD_TIMEOUT_RESULT;
                    if (kill_q || flush_i) begin
                        state_d = ST_IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (flush_i || ex_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pl_q     <= '0;
            kill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pl_q     <= pl_d;
            kill_q   <= kill_d;
            result_q <= result_d;
        end
    end

    assign ready_o        = (state_q == ST_IDLE) ? ~enable_i : (state_q == ST_DONE);
    assign valid_o        = (state_q == ST_DONE);
    assign result_o       = result_q;
    assign shd_req_o      = (state_q == ST_REQ);
    assign shd_op_o       = pl_q.op;
    assign shd_operands_o = {pl_q.c, pl_q.b, pl_q.a};
    assign shd_vec_mode_o = pl_q.vec_mode;

endmodule
